// File: rtl/maze_controller_if.sv
// Signal bundle between the maze controller and its datapath, deque, map memory and start/status logic.
// The master modport is the controller side and the slave modport is the datapath side.
interface maze_controller_if;
  logic       start;
  logic [3:0] X, Y;
  logic       is_full_X, is_full_Y, is_empty_X, is_empty_Y, Finish;
  logic [1:0] stack_out;
  logic [7:0] rd_addr;
  logic       rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       wr_data;
  logic       ld_X, ld_Y, iz_X, iz_Y, sel_X, sel_Y, sel_add, sel_sub, pX_nX, pY_nY;
  logic       push, pop_back, pop_front;
  logic [1:0] stack_in;
  logic       move_valid;
  logic       busy, done, fail;
  logic [7:0] depth;

  modport master (
    input  start, X, Y, is_full_X, is_full_Y, is_empty_X, is_empty_Y, Finish,
           stack_out, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data,
           ld_X, ld_Y, iz_X, iz_Y, sel_X, sel_Y, sel_add, sel_sub, pX_nX, pY_nY,
           push, pop_back, pop_front, stack_in, move_valid, busy, done, fail, depth
  );

  modport slave (
    output start, X, Y, is_full_X, is_full_Y, is_empty_X, is_empty_Y, Finish,
           stack_out, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data,
           ld_X, ld_Y, iz_X, iz_Y, sel_X, sel_Y, sel_add, sel_sub, pX_nX, pY_nY,
           push, pop_back, pop_front, stack_in, move_valid, busy, done, fail, depth
  );
endinterface

// File: rtl/maze_controller.sv
// Depth-first search sequencer for the 16x16 maze datapath, from (0,15) to (15,0).
// Define MAZE_REPLAY_EN to stream the solved path out of the deque in FIFO order after Finish.
module maze_controller #(
  parameter int MAX_DEPTH = 255
) (
  input logic              Clk,
  input logic              our_reset,
  maze_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_CHECK, S_EVAL, S_MOVE, S_BACK, S_BWAIT, S_BMOVE, S_REPLAY, S_DONE, S_FAIL
  } state_t;

  localparam logic [7:0] MAX_D = 8'(MAX_DEPTH);

  state_t     r_state, w_next;
  logic [2:0] r_dir;
  logic [1:0] r_m;
  logic [7:0] r_depth;
  logic [3:0] w_cand_x, w_cand_y;
  logic       w_off_grid, w_at_max, w_reject;
  logic [1:0] w_step;
`ifdef MAZE_REPLAY_EN
  logic       r_move_valid;
`endif

  // Candidate cell and boundary test for the direction currently being tried.
  always_comb begin
    w_cand_x   = bus.X;
    w_cand_y   = bus.Y;
    w_off_grid = 1'b0;
    case (r_dir[1:0])
      2'd0:    begin w_cand_x = bus.X + 4'd1; w_off_grid = bus.is_full_X;  end
      2'd1:    begin w_cand_y = bus.Y - 4'd1; w_off_grid = bus.is_empty_Y; end
      2'd2:    begin w_cand_x = bus.X - 4'd1; w_off_grid = bus.is_empty_X; end
      default: begin w_cand_y = bus.Y + 4'd1; w_off_grid = bus.is_full_Y;  end
    endcase
  end

  assign w_at_max = (r_depth == MAX_D);
  assign w_reject = w_off_grid || w_at_max;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge our_reset) begin
    if (our_reset) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: if (bus.start) w_next = S_INIT;
      S_INIT:  w_next = S_CHECK;
      S_CHECK: begin
        if (bus.Finish) begin
`ifdef MAZE_REPLAY_EN
          w_next = S_REPLAY;
`else
          w_next = S_DONE;
`endif
        end
        else if (r_dir[2]) w_next = S_BACK;
        else if (!w_reject) w_next = S_EVAL;
      end
      S_EVAL:  w_next = bus.rd_data ? S_CHECK : S_MOVE;
      S_MOVE:  w_next = S_CHECK;
      S_BACK:  w_next = (r_depth == 8'd0) ? S_FAIL : S_BWAIT;
      S_BWAIT: w_next = S_BMOVE;
      S_BMOVE: w_next = S_CHECK;
`ifdef MAZE_REPLAY_EN
      S_REPLAY: if (r_depth == 8'd0) w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Direction counter, latched backtrack move and deque occupancy.
  always_ff @(posedge Clk or posedge our_reset) begin
    if (our_reset) begin
      r_dir   <= 3'd0;
      r_m     <= 2'd0;
      r_depth <= 8'd0;
    end else begin
      case (r_state)
        S_INIT:  begin r_dir <= 3'd0; r_depth <= 8'd0; end
        S_CHECK: if (!bus.Finish && !r_dir[2] && w_reject) r_dir <= r_dir + 3'd1;
        S_EVAL:  if (bus.rd_data) r_dir <= r_dir + 3'd1;
        S_MOVE:  begin r_dir <= 3'd0; r_depth <= r_depth + 8'd1; end
        S_BACK:  if (r_depth != 8'd0) r_depth <= r_depth - 8'd1;
        S_BWAIT: r_m <= bus.stack_out;
        S_BMOVE: r_dir <= {1'b0, r_m} + 3'd1;
`ifdef MAZE_REPLAY_EN
        S_REPLAY: if (r_depth != 8'd0) r_depth <= r_depth - 8'd1;
`endif
        default: ;
      endcase
    end
  end

`ifdef MAZE_REPLAY_EN
  // The popped move appears on stack_out one cycle after pop_front.
  always_ff @(posedge Clk or posedge our_reset) begin
    if (our_reset) r_move_valid <= 1'b0;
    else           r_move_valid <= (r_state == S_REPLAY) && (r_depth != 8'd0);
  end
`endif

  // A backtrack applies the reverse of the popped move; a forward step applies dir.
  assign w_step = (r_state == S_BMOVE) ? (r_m ^ 2'b10) : r_dir[1:0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.rd_addr    = 8'd0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = 8'd0;
    bus.wr_data    = 1'b0;
    bus.ld_X       = 1'b0;
    bus.ld_Y       = 1'b0;
    bus.iz_X       = 1'b0;
    bus.iz_Y       = 1'b0;
    bus.sel_X      = 1'b0;
    bus.sel_Y      = 1'b0;
    bus.sel_add    = 1'b0;
    bus.sel_sub    = 1'b0;
    bus.pX_nX      = 1'b0;
    bus.pY_nY      = 1'b0;
    bus.push       = 1'b0;
    bus.pop_back   = 1'b0;
    bus.pop_front  = 1'b0;
    bus.stack_in   = 2'd0;
    bus.move_valid = 1'b0;
    bus.done       = 1'b0;
    bus.fail       = 1'b0;
    bus.busy       = !(r_state inside {S_IDLE, S_DONE, S_FAIL});
    bus.depth      = r_depth;
`ifdef MAZE_REPLAY_EN
    bus.move_valid = r_move_valid;
`endif
    case (r_state)
      S_INIT:  begin bus.iz_X = 1'b1; bus.iz_Y = 1'b1; end
      S_CHECK: bus.rd_addr = {w_cand_y, w_cand_x};
      S_MOVE, S_BMOVE: begin
        bus.sel_X   = !w_step[0];
        bus.sel_Y   = w_step[0];
        bus.pX_nX   = !w_step[0];
        bus.pY_nY   = w_step[0];
        bus.ld_X    = !w_step[0];
        bus.ld_Y    = w_step[0];
        bus.sel_add = (w_step == 2'd0) || (w_step == 2'd3);
        bus.sel_sub = (w_step == 2'd1) || (w_step == 2'd2);
        if (r_state == S_MOVE) begin
          bus.wr_en    = 1'b1;
          bus.wr_addr  = {bus.Y, bus.X};
          bus.wr_data  = 1'b1;
          bus.push     = 1'b1;
          bus.stack_in = r_dir[1:0];
        end
      end
      S_BACK:  bus.pop_back = (r_depth != 8'd0);
`ifdef MAZE_REPLAY_EN
      S_REPLAY: bus.pop_front = (r_depth != 8'd0);
`endif
      S_DONE:  bus.done = 1'b1;
      S_FAIL:  bus.fail = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_controller.sv
// Self-checking bench for maze_controller: models the datapath, deque and map memory around the DUT
// and compares each solve against hand-derived tables and a DFS reference model.
module tb_maze_controller;
  localparam int TB_MAX_DEPTH = 255;
  localparam int LIMIT        = 8000;

  logic Clk       = 1'b0;
  logic our_reset = 1'b0;
  always #5 Clk = ~Clk;

  maze_controller_if bus ();
  maze_controller #(.MAX_DEPTH(TB_MAX_DEPTH)) dut (.Clk(Clk), .our_reset(our_reset), .bus(bus));

  // Datapath model: coordinate registers, 1-cycle map memory, move deque.
  logic [3:0] r_x = 4'd0, r_y = 4'd15;
  logic       r_rdd = 1'b0;
  logic [1:0] r_so = 2'd0, pop_tmp;
  bit         mem   [256];
  bit         walls [256];
  logic [1:0] dq [$];

  assign bus.X          = r_x;
  assign bus.Y          = r_y;
  assign bus.is_full_X  = (r_x == 4'd15);
  assign bus.is_empty_X = (r_x == 4'd0);
  assign bus.is_full_Y  = (r_y == 4'd15);
  assign bus.is_empty_Y = (r_y == 4'd0);
  assign bus.Finish     = (r_x == 4'd15) && (r_y == 4'd0);
  assign bus.rd_data    = r_rdd;
  assign bus.stack_out  = r_so;

  always @(posedge Clk) begin
    if (bus.iz_X) r_x <= 4'd0;
    else if (bus.ld_X && bus.pX_nX && bus.sel_X) begin
      if (bus.sel_add) r_x <= r_x + 4'd1;
      else if (bus.sel_sub) r_x <= r_x - 4'd1;
    end
    if (bus.iz_Y) r_y <= 4'd15;
    else if (bus.ld_Y && bus.pY_nY && bus.sel_Y) begin
      if (bus.sel_add) r_y <= r_y + 4'd1;
      else if (bus.sel_sub) r_y <= r_y - 4'd1;
    end
    r_rdd <= mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
    if (bus.push) dq.push_back(bus.stack_in);
    if (bus.pop_back && dq.size() != 0) begin pop_tmp = dq.pop_back(); r_so <= pop_tmp; end
    if (bus.pop_front && dq.size() != 0) begin pop_tmp = dq.pop_front(); r_so <= pop_tmp; end
  end

  logic [44:0] all_out;
  assign all_out = {bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data, bus.ld_X, bus.ld_Y,
                    bus.iz_X, bus.iz_Y, bus.sel_X, bus.sel_Y, bus.sel_add, bus.sel_sub,
                    bus.pX_nX, bus.pY_nY, bus.push, bus.pop_back, bus.pop_front, bus.stack_in,
                    bus.move_valid, bus.busy, bus.done, bus.fail, bus.depth};

  int vec_cnt = 0, miss_cnt = 0;
  logic [1:0] obs_push [$], obs_replay [$], exp_push [$], exp_replay [$];
  int obs_pb, obs_pf, obs_mv, obs_cycles, onehot_err, first_busy, first_done, timed_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Load the map, pulse start, and record everything the controller does until done/fail.
  task automatic apply_run(input int extra_start);
    int n;
    obs_push.delete(); obs_replay.delete();
    obs_pb = 0; obs_pf = 0; obs_mv = 0; obs_cycles = 0; onehot_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = walls[i];
    dq.delete();
    @(negedge Clk); bus.start = 1'b1;
    @(negedge Clk); bus.start = 1'b0;
    first_busy = bus.busy;
    first_done = bus.done;
    n = 0;
    while (!(bus.done || bus.fail) && n < LIMIT) begin
      if (bus.busy) obs_cycles++;
      if (bus.push) obs_push.push_back(bus.stack_in);
      if (bus.pop_back) obs_pb++;
      if (bus.pop_front) obs_pf++;
      if (bus.move_valid) begin obs_mv++; obs_replay.push_back(bus.stack_out); end
      if ($countones({bus.push, bus.pop_back, bus.pop_front}) > 1) onehot_err++;
      bus.start = (n == extra_start);
      @(negedge Clk);
      n++;
    end
    bus.start = 1'b0;
    timed_out = (n >= LIMIT) ? 1 : 0;
  endtask

  // Reference DFS over the wall map: moves, backtracks and cycle cost per candidate outcome.
  task automatic model_run(output bit m_fail, output int m_x, output int m_y,
                           output int m_pb, output int m_cycles);
    bit vis [256];
    int x, y, d, nx, ny;
    logic [1:0] m;
    int dx [4] = '{1, 0, -1, 0};
    int dy [4] = '{0, -1, 0, 1};
    exp_push.delete(); exp_replay.delete();
    vis = walls;
    x = 0; y = 15; d = 0;
    m_pb = 0; m_cycles = 1; m_fail = 1'b0;
    for (int guard = 0; guard < 100000; guard++) begin
      if (x == 15 && y == 0) begin m_cycles++; break; end
      if (d == 4) begin
        m_cycles++;
        if (exp_replay.size() == 0) begin m_cycles++; m_fail = 1'b1; break; end
        m = exp_replay.pop_back();
        m_pb++;
        x -= dx[m]; y -= dy[m];
        d = int'(m) + 1;
        m_cycles += 3;
        continue;
      end
      nx = x + dx[d]; ny = y + dy[d];
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15 || exp_replay.size() == TB_MAX_DEPTH) begin
        m_cycles++; d++; continue;
      end
      if (vis[ny*16 + nx]) begin m_cycles += 2; d++; continue; end
      vis[y*16 + x] = 1'b1;
      x = nx; y = ny;
      exp_replay.push_back(2'(d));
      exp_push.push_back(2'(d));
      m_cycles += 3;
      d = 0;
    end
    m_x = x; m_y = y;
  endtask

  task automatic eval_run(input string tag, input bit e_fail, input int e_x, input int e_y,
                          input int e_pb, input int e_cycles);
    int bad, e_depth, e_cyc;
    e_cyc = e_cycles; e_depth = 0;
`ifdef MAZE_REPLAY_EN
    if (!e_fail) e_cyc += exp_replay.size() + 1;
`else
    if (!e_fail) e_depth = exp_replay.size();
`endif
    check({tag, ".timeout"}, timed_out, 0);
    check({tag, ".done"}, bus.done, !e_fail);
    check({tag, ".fail"}, bus.fail, e_fail);
    check({tag, ".x"}, r_x, e_x);
    check({tag, ".y"}, r_y, e_y);
    check({tag, ".depth"}, bus.depth, e_depth);
    check({tag, ".npush"}, obs_push.size(), exp_push.size());
    bad = 0;
    for (int i = 0; i < obs_push.size() && i < exp_push.size(); i++)
      if (obs_push[i] !== exp_push[i]) bad++;
    check({tag, ".push_seq"}, bad, 0);
    check({tag, ".pop_back"}, obs_pb, e_pb);
    check({tag, ".cycles"}, obs_cycles, e_cyc);
    check({tag, ".init_busy"}, first_busy, 1);
    check({tag, ".init_done"}, first_done, 0);
    check({tag, ".onehot"}, onehot_err, 0);
`ifdef MAZE_REPLAY_EN
    check({tag, ".nreplay"}, obs_replay.size(), e_fail ? 0 : exp_replay.size());
    bad = 0;
    for (int i = 0; i < obs_replay.size() && i < exp_replay.size(); i++)
      if (obs_replay[i] !== exp_replay[i]) bad++;
    check({tag, ".replay_seq"}, bad, 0);
`else
    check({tag, ".pop_front"}, obs_pf, 0);
    check({tag, ".move_valid"}, obs_mv, 0);
`endif
  endtask

  typedef struct {
    string name;
    int    wall [3];
    int    extra_start;
    bit    e_fail;
    int    e_x, e_y, n0, n1, e_pb, e_cycles;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n, bad_ctl, m_x, m_y, m_pb, m_cyc;
    bit m_fail;
    bus.start = 1'b0;

    // Wall cells are {Y,X}: (1,15)=241, (0,14)=224, (1,14)=225, (0,13)=208.
    tbl[0] = '{"open",       '{-1, -1, -1}, -1, 1'b0, 15, 0, 15, 15, 0, 107};
    tbl[1] = '{"walled",     '{241, 224, -1}, -1, 1'b1, 0, 15, 0, 0, 0, 9};
    tbl[2] = '{"dead_end",   '{241, 225, 208}, -1, 1'b1, 0, 15, 0, 1, 1, 21};
    tbl[3] = '{"start_busy", '{-1, -1, -1}, 12, 1'b0, 15, 0, 15, 15, 0, 107};
    tbl[4] = '{"rerun",      '{-1, -1, -1}, -1, 1'b0, 15, 0, 15, 15, 0, 107};

    #2 our_reset = 1'b1;
    #1 check("reset.outputs", all_out === 45'd0, 1);
    repeat (2) @(negedge Clk);
    check("reset.held_outputs", all_out === 45'd0, 1);
    our_reset = 1'b0;
    @(negedge Clk);
    check("idle.outputs", all_out === 45'd0, 1);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 256; i++) walls[i] = 1'b0;
      for (int k = 0; k < 3; k++) if (tbl[t].wall[k] >= 0) walls[tbl[t].wall[k]] = 1'b1;
      exp_push.delete(); exp_replay.delete();
      for (int i = 0; i < tbl[t].n0; i++) exp_push.push_back(2'd0);
      for (int i = 0; i < tbl[t].n1; i++) exp_push.push_back(2'd1);
      if (!tbl[t].e_fail) exp_replay = exp_push;
      apply_run(tbl[t].extra_start);
      eval_run(tbl[t].name, tbl[t].e_fail, tbl[t].e_x, tbl[t].e_y, tbl[t].e_pb, tbl[t].e_cycles);
    end

    // Reset asserted while the controller is in MOVE.
    for (int i = 0; i < 256; i++) begin walls[i] = 1'b0; mem[i] = 1'b0; end
    dq.delete();
    @(negedge Clk); bus.start = 1'b1;
    @(negedge Clk); bus.start = 1'b0;
    n = 0;
    while (!bus.push && n < 200) begin @(negedge Clk); n++; end
    check("rst.reach_move", bus.push, 1);
    our_reset = 1'b1;
    #1 check("rst.outputs_now", all_out === 45'd0, 1);
    bad_ctl = 0;
    repeat (3) begin
      @(negedge Clk);
      bad_ctl += $countones({bus.push, bus.ld_X, bus.ld_Y, bus.busy});
    end
    our_reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      bad_ctl += $countones({bus.push, bus.ld_X, bus.ld_Y, bus.busy});
    end
    check("rst.no_activity", bad_ctl, 0);
    check("rst.idle_outputs", all_out === 45'd0, 1);

    // Random maps against the reference DFS.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 256; i++) walls[i] = ($urandom_range(0, 99) < 28);
      walls[240] = 1'b0;
      walls[255] = 1'b0;
      model_run(m_fail, m_x, m_y, m_pb, m_cyc);
      apply_run(-1);
      eval_run($sformatf("rand%0d", r), m_fail, m_x, m_y, m_pb, m_cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
